// File: rtl/hazard_ctrl_if.sv
// Bundle between the decode/execute stage and the hazard controller.
// The pipeline side drives through "master"; the controller uses "slave".
interface hazard_ctrl_if #(
  parameter int FWD_STAGES = 1,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
  logic [4:0]              raddr1;
  logic [4:0]              raddr2;
  logic [FWD_STAGES-1:0]   stg_reg_wr;
  logic [5*FWD_STAGES-1:0] stg_waddr;
  logic [FWD_STAGES-1:0]   stg_is_load;
  logic                    dmem_rsp_valid;
  logic                    pc_src;
  logic [SEL_W-1:0]        For_A;
  logic [SEL_W-1:0]        For_B;
  logic                    Stall;
  logic                    Stall_MW;
  logic                    Flush;
  logic                    err_timeout;
  logic [31:0]             stall_cnt;
  logic [31:0]             flush_cnt;

  modport master (
    output raddr1, raddr2, stg_reg_wr, stg_waddr, stg_is_load, dmem_rsp_valid, pc_src,
    input  For_A, For_B, Stall, Stall_MW, Flush, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  raddr1, raddr2, stg_reg_wr, stg_waddr, stg_is_load, dmem_rsp_valid, pc_src,
    output For_A, For_B, Stall, Stall_MW, Flush, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I hazard controller: multi-stage forwarding with nearest-stage priority,
// load-use stall until the data memory responds, and multi-cycle branch flush.
module hazard_ctrl #(
  parameter int FWD_STAGES    = 1,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 64,
  parameter int SEL_W         = $clog2(FWD_STAGES + 1)
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  localparam int WC_W = 10;
  localparam int FC_W = 2;

  typedef enum logic { LD_IDLE, LD_WAIT  } ld_state_t;
  typedef enum logic { FL_IDLE, FL_FLUSH } fl_state_t;

  logic [FWD_STAGES-1:0] w_match_a;
  logic [FWD_STAGES-1:0] w_match_b;
  logic [SEL_W-1:0]      w_for_a;
  logic [SEL_W-1:0]      w_for_b;
  logic                  w_stall;
  logic                  w_unused_load;

  ld_state_t   r_ld_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic        r_err_timeout;
  fl_state_t   r_fl_state;
  logic [FC_W-1:0] r_fcnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Only stage 0 can cause a load-use stall; deeper load flags are informational.
  assign w_unused_load = ^bus.stg_is_load;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      w_match_a[k] = bus.stg_reg_wr[k] && (bus.stg_waddr[5*k +: 5] == bus.raddr1)
                     && (bus.raddr1 != 5'd0);
      w_match_b[k] = bus.stg_reg_wr[k] && (bus.stg_waddr[5*k +: 5] == bus.raddr2)
                     && (bus.raddr2 != 5'd0);
    end
  end

  // Scan from the far stage inward so the nearest match is the last one written.
  always_comb begin
    w_for_a = '0;
    w_for_b = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (w_match_a[k]) w_for_a = SEL_W'(k + 1);
      if (w_match_b[k]) w_for_b = SEL_W'(k + 1);
    end
  end

  assign w_stall = (w_match_a[0] || w_match_b[0]) && bus.stg_is_load[0]
                   && !bus.dmem_rsp_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_state    <= LD_IDLE;
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_ld_state)
        LD_IDLE: begin
          r_wait_cnt <= '0;
          if (w_stall) r_ld_state <= LD_WAIT;
        end
        LD_WAIT: begin
          if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
          // The count reaches STALL_TIMEOUT on this edge; error is sticky.
          if (r_wait_cnt == WC_W'(STALL_TIMEOUT - 1)) r_err_timeout <= 1'b1;
          if (!w_stall) r_ld_state <= LD_IDLE;
        end
        default: r_ld_state <= LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fl_state <= FL_IDLE;
      r_fcnt     <= '0;
    end else if (bus.pc_src) begin
      // A new taken branch restarts the bubble train rather than extending it.
      r_fcnt     <= FC_W'(FLUSH_CYCLES - 1);
      r_fl_state <= (FLUSH_CYCLES > 1) ? FL_FLUSH : FL_IDLE;
    end else if (r_fl_state == FL_FLUSH && !w_stall) begin
      if (r_fcnt <= FC_W'(1)) begin
        r_fcnt     <= '0;
        r_fl_state <= FL_IDLE;
      end else begin
        r_fcnt <= r_fcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.Flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.For_A       = w_for_a;
  assign bus.For_B       = w_for_b;
  assign bus.Stall       = w_stall;
  assign bus.Stall_MW    = w_stall;
  assign bus.Flush       = bus.pc_src || (r_fl_state == FL_FLUSH);
  assign bus.err_timeout = r_err_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule
